// File: rtl/reg_write_arbiter.sv
// Register-file write-port owner: zero-fills R0..R(NUM_REGS-2) after reset, then
// round-robin arbitrates writeback (A) and load-return/debug (B) onto one port.
module reg_write_arbiter #(
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int AW             = $clog2(NUM_REGS),
  parameter int DW             = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          busy
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam state_t        RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
  localparam logic [AW-1:0] LAST_CLR  = AW'(NUM_REGS - 2);
  localparam logic [AW-1:0] ZERO_REG  = AW'(NUM_REGS - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          r_last_b;   // 1: B won the most recent grant
  logic          r_rf_we;
  logic [AW-1:0] r_rf_wa;
  logic [DW-1:0] r_rf_wd;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (r_clr_cnt == LAST_CLR) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // ready is gated by rst so nothing is accepted on a reset edge
        if (!rst) begin
          a_ready = a_valid && (!b_valid || r_last_b);
          b_ready = b_valid && !(a_valid && (!b_valid || r_last_b));
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we   <= 1'b0;
      r_rf_wa   <= '0;
      r_rf_wd   <= '0;
      r_clr_cnt <= '0;
      r_last_b  <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_rf_we   <= 1'b1;
      r_rf_wa   <= r_clr_cnt;
      r_rf_wd   <= '0;
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end else if (a_ready) begin
      r_last_b <= 1'b0;
      r_rf_we  <= (a_addr != ZERO_REG);
      if (a_addr != ZERO_REG) begin
        r_rf_wa <= a_addr;
        r_rf_wd <= a_data;
      end
    end else if (b_ready) begin
      r_last_b <= 1'b1;
      r_rf_we  <= (b_addr != ZERO_REG);
      if (b_addr != ZERO_REG) begin
        r_rf_wa <= b_addr;
        r_rf_wd <= b_data;
      end
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  assign rf_we = r_rf_we;
  assign rf_wa = r_rf_wa;
  assign rf_wd = r_rf_wd;

endmodule
